// File: rtl/axi4_mst_pkg.sv
// Shared AXI4 encodings, W-channel FSM states and the command legality check
// used by the AXI4 write master.
package axi4_mst_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] AWCACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] AWPROT_DEFAULT  = 3'b000;
  localparam logic       AWLOCK_DEFAULT  = 1'b0;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_DATA = 1'b1
  } w_state_e;

  // Reserved burst type, WRAP with a non power-of-two beat count, or a beat wider than the bus.
  function automatic logic cmd_is_illegal(input logic [1:0] burst, input logic [7:0] len,
                                          input logic [2:0] size, input logic [2:0] max_size);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok) || (size > max_size);
  endfunction

endpackage

// File: rtl/axi_len_fifo.sv
// Burst-length FIFO between AW issue and W data; show-ahead read, push and pop
// may coincide at any occupancy.
module axi_len_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == {CNT_W{1'b0}});
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone defines which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/axi4_write_master.sv
// AXI4 write master: registered AW issue with outstanding tracking, a length FIFO
// feeding a pass-through W burst sequencer, and a combinational B-to-response path.
module axi4_write_master
  import axi4_mst_pkg::*;
#(
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int ID_W      = 4,
  parameter  int MAX_OUTST = 4,
  localparam int STRB_W    = DATA_W / 8,
  localparam int CNT_W     = $clog2(MAX_OUTST) + 1
) (
  input  logic              AClk,
  input  logic              ARst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  input  logic [STRB_W-1:0] wd_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [1:0]        rsp_resp,
  output logic [ID_W-1:0]   AWID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWLOCK,
  output logic [3:0]        AWCACHE,
  output logic [2:0]        AWPROT,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [ID_W-1:0]   BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [CNT_W-1:0]  outst_cnt,
  output logic              err_cmd,
  output logic              err_b
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTST);
  localparam logic [2:0]       MAX_SIZE = 3'($clog2(STRB_W));

  logic [ID_W-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]        aw_len_q, aw_len_d;
  logic [2:0]        aw_size_q, aw_size_d;
  logic [1:0]        aw_burst_q, aw_burst_d;
  logic              aw_valid_q, aw_valid_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic              err_cmd_q, err_cmd_d, err_b_q, err_b_d;
  w_state_e          w_state_q, w_state_d;
  logic [7:0]        beat_q, beat_d, len_q, len_d;
  logic              cmd_fire, b_fire, w_fire, in_data, is_last;
  logic              lenq_pop, lenq_full, lenq_empty;
  logic [7:0]        lenq_data;

  axi_len_fifo #(.DEPTH(MAX_OUTST)) u_lenq (
    .clk_i  (AClk),
    .rst_i  (ARst),
    .push_i (cmd_fire),
    .data_i (cmd_len),
    .pop_i  (lenq_pop),
    .data_o (lenq_data),
    .full_o (lenq_full),
    .empty_o(lenq_empty)
  );

  // Holding AWVALID low between commands limits issue to one per two cycles.
  assign cmd_ready = !ARst && !aw_valid_q && (outst_q < MAX_CNT) && !lenq_full;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign BREADY    = !ARst && rsp_ready;
  assign rsp_valid = !ARst && BVALID;
  assign rsp_id    = BID;
  assign rsp_resp  = BRESP;
  assign b_fire    = BVALID && BREADY;

  assign AWID      = aw_id_q;
  assign AWADDR    = aw_addr_q;
  assign AWLEN     = aw_len_q;
  assign AWSIZE    = aw_size_q;
  assign AWBURST   = aw_burst_q;
  assign AWLOCK    = AWLOCK_DEFAULT;
  assign AWCACHE   = AWCACHE_DEFAULT;
  assign AWPROT    = AWPROT_DEFAULT;
  assign AWVALID   = aw_valid_q;
  assign outst_cnt = outst_q;
  assign err_cmd   = err_cmd_q;
  assign err_b     = err_b_q;

  assign in_data  = (w_state_q == W_DATA);
  assign is_last  = in_data && (beat_q == len_q);
  assign WVALID   = in_data && wd_valid;
  assign wd_ready = in_data && WREADY;
  assign WDATA    = in_data ? wd_data : {DATA_W{1'b0}};
  assign WSTRB    = in_data ? wd_strb : {STRB_W{1'b0}};
  assign WLAST    = is_last;
  assign w_fire   = WVALID && WREADY;

  always_comb begin
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    aw_valid_d = aw_valid_q;
    err_cmd_d  = err_cmd_q;
    if (cmd_fire) begin
      aw_id_d    = cmd_id;
      aw_addr_d  = cmd_addr;
      aw_len_d   = cmd_len;
      aw_size_d  = cmd_size;
      aw_burst_d = cmd_burst;
      aw_valid_d = 1'b1;
      err_cmd_d  = err_cmd_q | cmd_is_illegal(cmd_burst, cmd_len, cmd_size, MAX_SIZE);
    end else if (AWREADY) begin
      aw_valid_d = 1'b0;
    end else begin
      aw_valid_d = aw_valid_q;
    end
    // A B with nothing outstanding is flagged and never drives the count below zero.
    err_b_d = err_b_q | (b_fire && (outst_q == {CNT_W{1'b0}}));
    case ({cmd_fire, b_fire})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = (outst_q == {CNT_W{1'b0}}) ? outst_q : outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    beat_d    = beat_q;
    len_d     = len_q;
    lenq_pop  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (!lenq_empty) begin
          lenq_pop  = 1'b1;
          len_d     = lenq_data;
          beat_d    = 8'd0;
          w_state_d = W_DATA;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_fire && is_last) begin
          beat_d = 8'd0;
          // Chain straight into the next queued burst so W never idles between bursts.
          if (!lenq_empty) begin
            lenq_pop = 1'b1;
            len_d    = lenq_data;
          end else begin
            w_state_d = W_IDLE;
          end
        end else if (w_fire) begin
          beat_d = beat_q + 8'd1;
        end else begin
          beat_d = beat_q;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge AClk or posedge ARst) begin
    if (ARst) begin
      aw_id_q    <= {ID_W{1'b0}};
      aw_addr_q  <= {ADDR_W{1'b0}};
      aw_len_q   <= 8'd0;
      aw_size_q  <= 3'd0;
      aw_burst_q <= 2'd0;
      aw_valid_q <= 1'b0;
      outst_q    <= {CNT_W{1'b0}};
      err_cmd_q  <= 1'b0;
      err_b_q    <= 1'b0;
      w_state_q  <= W_IDLE;
      beat_q     <= 8'd0;
      len_q      <= 8'd0;
    end else begin
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      aw_valid_q <= aw_valid_d;
      outst_q    <= outst_d;
      err_cmd_q  <= err_cmd_d;
      err_b_q    <= err_b_d;
      w_state_q  <= w_state_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
    end
  end

endmodule

// File: tb/tb_axi4_write_master.sv
// Directed bench for axi4_write_master: a table of command-legality vectors plus
// hand-written sequences for bursts, back-pressure, outstanding limit and reset.
module tb_axi4_write_master;
  import axi4_mst_pkg::*;

  logic        AClk, ARst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        rsp_valid, rsp_ready;
  logic [3:0]  rsp_id;
  logic [1:0]  rsp_resp;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWLOCK;
  logic [3:0]  AWCACHE;
  logic [2:0]  AWPROT;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic [2:0]  outst_cnt;
  logic        err_cmd, err_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] burst;
    logic [7:0] len;
    logic [2:0] size;
    logic       exp_err;
  } err_vec_t;

  err_vec_t vecs [8];

  axi4_write_master #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .MAX_OUTST(4)) dut (
    .AClk(AClk), .ARst(ARst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_resp(rsp_resp),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .outst_cnt(outst_cnt), .err_cmd(err_cmd), .err_b(err_b)
  );

  initial AClk = 1'b0;
  always #5 AClk = ~AClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge AClk);
    #1;
  endtask

  task automatic do_reset();
    ARst = 1'b1;
    cmd_valid = 1'b0; wd_valid = 1'b0; BVALID = 1'b0; rsp_ready = 1'b0;
    repeat (2) tick();
    ARst = 1'b0;
  endtask

  task automatic issue_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    logic ok;
    ok = 1'b0;
    cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
    cmd_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge AClk);
      ok = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    check("cmd_accept", 64'(ok), 64'(1));
  endtask

  // Sends n beats; bl is the beat count of every burst in the group.
  task automatic send_beats(input int n, input int bl, input logic [31:0] base, output int stalls);
    logic got;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      wd_valid = 1'b1;
      wd_data  = base + 32'(i);
      wd_strb  = 4'hF ^ 4'(i);
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge AClk);
        if (WVALID && wd_ready) begin
          got = 1'b1;
          check("w_data", 64'(WDATA), 64'(base + 32'(i)));
          check("w_strb", 64'(WSTRB), 64'(4'hF ^ 4'(i)));
          check("w_last", 64'(WLAST), 64'((i % bl) == (bl - 1)));
        end else begin
          stalls++;
        end
        tick();
      end
      if (!got) check("w_beat_timeout", 64'(0), 64'(1));
    end
    wd_valid = 1'b0;
  endtask

  task automatic b_resp(input logic [3:0] id, input logic [1:0] resp);
    BVALID = 1'b1; BID = id; BRESP = resp; rsp_ready = 1'b1;
    @(negedge AClk);
    check("rsp_valid", 64'(rsp_valid), 64'(1));
    check("rsp_id", 64'(rsp_id), 64'(id));
    check("rsp_resp", 64'(rsp_resp), 64'(resp));
    check("bready", 64'(BREADY), 64'(1));
    tick();
    BVALID = 1'b0; rsp_ready = 1'b0;
  endtask

  initial begin
    int st;
    vecs[0] = '{BURST_INCR,  8'd3,  3'd2, 1'b0};
    vecs[1] = '{BURST_WRAP,  8'd2,  3'd2, 1'b1};
    vecs[2] = '{BURST_WRAP,  8'd3,  3'd2, 1'b0};
    vecs[3] = '{BURST_WRAP,  8'd15, 3'd1, 1'b0};
    vecs[4] = '{BURST_WRAP,  8'd4,  3'd2, 1'b1};
    vecs[5] = '{BURST_RSVD,  8'd0,  3'd0, 1'b1};
    vecs[6] = '{BURST_FIXED, 8'd0,  3'd3, 1'b1};
    vecs[7] = '{BURST_FIXED, 8'd7,  3'd2, 1'b0};

    ARst = 1'b1; cmd_valid = 1'b0; cmd_id = 4'd0; cmd_addr = 32'd0; cmd_len = 8'd0;
    cmd_size = 3'd0; cmd_burst = 2'd0; wd_valid = 1'b0; wd_data = 32'd0; wd_strb = 4'd0;
    rsp_ready = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; BID = 4'd0; BRESP = 2'd0; BVALID = 1'b0;

    // Reset state
    @(negedge AClk);
    check("rst_awvalid", 64'(AWVALID), 64'(0));
    check("rst_wvalid", 64'(WVALID), 64'(0));
    check("rst_wlast", 64'(WLAST), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_outst", 64'(outst_cnt), 64'(0));
    check("rst_err", 64'({err_cmd, err_b}), 64'(0));
    check("rst_awaddr", 64'(AWADDR), 64'(0));
    tick();
    ARst = 1'b0;

    // Single INCR burst
    AWREADY = 1'b1; WREADY = 1'b1;
    issue_cmd(4'd5, 32'h1000, 8'd3, 3'd2, BURST_INCR);
    @(negedge AClk);
    check("t1_awvalid", 64'(AWVALID), 64'(1));
    check("t1_awaddr", 64'(AWADDR), 64'(32'h1000));
    check("t1_awid", 64'(AWID), 64'(5));
    check("t1_awlen", 64'(AWLEN), 64'(3));
    check("t1_awsize_burst", 64'({AWSIZE, AWBURST}), 64'({3'd2, BURST_INCR}));
    check("t1_aw_consts", 64'({AWLOCK, AWCACHE, AWPROT}), 64'({1'b0, 4'b0011, 3'b000}));
    check("t1_outst", 64'(outst_cnt), 64'(1));
    check("t1_cmd_ready_busy", 64'(cmd_ready), 64'(0));
    tick();
    @(negedge AClk);
    check("t1_awvalid_drop", 64'(AWVALID), 64'(0));
    tick();
    send_beats(4, 4, 32'hA000_0000, st);
    check("t1_stalls", 64'(st), 64'(0));
    wd_valid = 1'b1;
    @(negedge AClk);
    check("t1_w_gated", 64'({WVALID, wd_ready, WLAST}), 64'(0));
    wd_valid = 1'b0;
    tick();
    b_resp(4'd5, RESP_OKAY);
    @(negedge AClk);
    check("t1_outst_end", 64'(outst_cnt), 64'(0));
    tick();

    // Back-to-back bursts with no idle cycle
    issue_cmd(4'd1, 32'h0100, 8'd1, 3'd2, BURST_INCR);
    issue_cmd(4'd2, 32'h0200, 8'd1, 3'd2, BURST_INCR);
    send_beats(4, 2, 32'hB000_0000, st);
    check("t2_stalls", 64'(st), 64'(0));
    @(negedge AClk);
    check("t2_outst", 64'(outst_cnt), 64'(2));
    tick();
    b_resp(4'd1, RESP_OKAY);
    b_resp(4'd2, RESP_EXOKAY);
    @(negedge AClk);
    check("t2_outst_end", 64'(outst_cnt), 64'(0));
    tick();

    // Outstanding limit
    for (int c = 0; c < 4; c++) issue_cmd(4'(c), 32'h0300 + 32'(c * 16), 8'd0, 3'd2, BURST_INCR);
    cmd_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge AClk);
      check("t3_cmd_ready_full", 64'(cmd_ready), 64'(0));
      tick();
    end
    cmd_valid = 1'b0;
    check("t3_outst_max", 64'(outst_cnt), 64'(4));
    b_resp(4'd0, RESP_OKAY);
    @(negedge AClk);
    check("t3_outst_3", 64'(outst_cnt), 64'(3));
    check("t3_cmd_ready_back", 64'(cmd_ready), 64'(1));
    tick();
    // Command accept and B handshake in the same cycle
    cmd_id = 4'd9; cmd_len = 8'd0; cmd_burst = BURST_INCR; cmd_size = 3'd2;
    cmd_valid = 1'b1; BVALID = 1'b1; BID = 4'd1; BRESP = RESP_OKAY; rsp_ready = 1'b1;
    @(negedge AClk);
    check("t3_both_ready", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0; BVALID = 1'b0; rsp_ready = 1'b0;
    @(negedge AClk);
    check("t3_both_outst", 64'(outst_cnt), 64'(3));
    check("t3_both_awvalid", 64'(AWVALID), 64'(1));
    check("t3_no_err_b", 64'(err_b), 64'(0));
    tick();
    send_beats(5, 1, 32'hC000_0000, st);
    for (int c = 0; c < 3; c++) b_resp(4'(c + 2), RESP_OKAY);
    @(negedge AClk);
    check("t3_outst_end", 64'(outst_cnt), 64'(0));
    tick();

    // AWREADY stall while W beats proceed
    AWREADY = 1'b0;
    issue_cmd(4'd3, 32'h2000, 8'd3, 3'd2, BURST_INCR);
    send_beats(4, 4, 32'hD000_0000, st);
    check("t4_first_w_latency", 64'(st), 64'(1));
    @(negedge AClk);
    check("t4_awvalid_held", 64'(AWVALID), 64'(1));
    check("t4_aw_stable", 64'({AWID, AWADDR, AWLEN}), 64'({4'd3, 32'h2000, 8'd3}));
    check("t4_cmd_ready", 64'(cmd_ready), 64'(0));
    AWREADY = 1'b1;
    tick();
    @(negedge AClk);
    check("t4_awvalid_drop", 64'(AWVALID), 64'(0));
    tick();
    b_resp(4'd3, RESP_SLVERR);

    // Command legality table, one reset per vector
    for (int v = 0; v < 8; v++) begin
      do_reset();
      issue_cmd(4'(v), 32'h5000, vecs[v].len, vecs[v].size, vecs[v].burst);
      @(negedge AClk);
      check("err_cmd_vec", 64'(err_cmd), 64'(vecs[v].exp_err));
      check("err_vec_issued", 64'({AWVALID, AWBURST, AWLEN, AWSIZE}),
            64'({1'b1, vecs[v].burst, vecs[v].len, vecs[v].size}));
      tick();
    end

    // B with nothing outstanding
    do_reset();
    @(negedge AClk);
    check("errb_before", 64'(err_b), 64'(0));
    tick();
    b_resp(4'd2, RESP_SLVERR);
    @(negedge AClk);
    check("errb_set", 64'(err_b), 64'(1));
    check("errb_outst", 64'(outst_cnt), 64'(0));
    check("errb_no_cmd_err", 64'(err_cmd), 64'(0));
    tick();

    // Reset in the middle of a burst
    do_reset();
    AWREADY = 1'b0; WREADY = 1'b1;
    issue_cmd(4'd7, 32'h3000, 8'd3, 3'd2, BURST_INCR);
    send_beats(2, 4, 32'hE000_0000, st);
    wd_valid = 1'b1;
    @(negedge AClk);
    check("t6_pre_wvalid", 64'(WVALID), 64'(1));
    #2 ARst = 1'b1;
    #1;
    check("t6_rst_wvalid", 64'(WVALID), 64'(0));
    check("t6_rst_awvalid", 64'(AWVALID), 64'(0));
    check("t6_rst_outst", 64'(outst_cnt), 64'(0));
    tick();
    ARst = 1'b0;
    @(negedge AClk);
    check("t6_dropped", 64'(WVALID), 64'(0));
    tick();
    wd_valid = 1'b0;
    AWREADY = 1'b1;
    issue_cmd(4'd8, 32'h4000, 8'd0, 3'd2, BURST_INCR);
    send_beats(1, 1, 32'hF000_0000, st);
    b_resp(4'd8, RESP_OKAY);
    @(negedge AClk);
    check("t6_outst_end", 64'(outst_cnt), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
